fpaddsub_arb: RTL and testbench
===============================

FPADDSUB_ARB -- requirements
Module: fpaddsub_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LOG_BIT, default 5, log2 of the operand width.
REQ-003 SHALL have parameter EXP_BIT, default 8, exponent width; N_BIT = 1<<LOG_BIT.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ, per-requester operation valid.
REQ-007 SHALL have port req_ready, output, N_REQ, per-requester accept (at most one bit high).
REQ-008 SHALL have port req_a, input, N_REQ x N_BIT, first operand per requester.
REQ-009 SHALL have port req_b, input, N_REQ x N_BIT, second operand per requester.
REQ-010 SHALL have port req_sub, input, N_REQ, op select: 1 = a-b, 0 = a+b.
REQ-011 SHALL have port rsp_valid, output, 1, result valid.
REQ-012 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port rsp_data, output, N_BIT, IEEE-style add/sub result.
REQ-014 SHALL have port rsp_id, output, clog2(N_REQ), index of the originating requester.
REQ-015 SHALL have port busy, output, 1, high while any pipeline stage holds an operation.

Function
REQ-016 SHALL share one add/sub datapath instance between all requesters through a 2-stage pipeline: S1 (registered operands, op, id) feeding the combinational datapath, S2 (registered result, id).
REQ-017 SHALL accept one request per cycle maximum; handshake on req_i = req_valid[i] & req_ready[i].
REQ-018 SHALL assert req_ready[w] only for the arbitration winner w among asserted req_valid, and only when S1 can load (S1 empty or S1 advancing).
REQ-019 SHALL make req_ready combinationally dependent on req_valid and rsp_ready; requesters must not gate req_valid on req_ready.
REQ-020 SHALL produce rsp_valid exactly 2 cycles after an accepted handshake when rsp_ready stays high; sustained throughput 1 op/cycle.
REQ-021 SHALL advance S2 when S2 is empty or rsp_ready=1; S1 advances when S1 holds an operation and S2 advances.
REQ-022 SHALL hold rsp_data/rsp_id stable while rsp_valid=1 and rsp_ready=0; no operation lost or duplicated.
REQ-023 SHALL, with both stages full and rsp_ready=0, drive all req_ready low.
REQ-024 SHALL pass req_sub to the datapath operation-select unmodified; result encoding (NaN, Inf, zero, rounding) is entirely the datapath's.
REQ-025 SHALL drive busy = S1_valid | S2_valid.
REQ-026 SHALL return results in acceptance order.

Reset
REQ-027 SHALL on rst clear S1_valid, S2_valid, rsp_valid, busy, rr pointer to 0, and rsp_data, rsp_id to 0.
REQ-028 SHALL discard in-flight operations on rst mid-operation; first accept after release in the first cycle rst is low.

Configuration
REQ-029 SHALL, with FPADDSUB_ARB_RR_EN defined, use round-robin: search starts at rr pointer; on handshake pointer = (w+1) mod N_REQ; pointer unchanged without handshake.
REQ-030 SHALL, without FPADDSUB_ARB_RR_EN, use fixed priority: lowest asserted index wins; no pointer register.

Structure
REQ-031 SHALL place N_BIT derivation, the requester-id typedef and the S1/S2 stage struct typedefs in package fpaddsub_arb_pkg.
REQ-032 SHALL instantiate the existing fpaddsub module as its only sub-module, between S1 and S2.

Verification
REQ-033 SHALL cover: req 0 a=0x3F800000 b=0x40000000 sub=0 -> rsp_data=0x40400000, rsp_id=0, two cycles later.
REQ-034 SHALL cover: all 4 valid continuously, RR enabled, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; fixed prio -> req 0 every cycle.
REQ-035 SHALL cover: rsp_ready=0 for 4 cycles with continuous requests -> exactly 2 accepts, then req_ready all low; results drain in order, none lost.
REQ-036 SHALL cover: a=0x3F800000 b=0x3F800000 sub=1 -> 0x00000000; a=0x7FC00000 -> 0x7FC00000.
REQ-037 SHALL cover: rst asserted with both stages full -> rsp_valid, busy low next cycle, no stale response after release.

Source files
------------

// File: rtl/fpaddsub_arb_pkg.sv
// Shared widths, requester id type and pipeline stage bundles for
// the fpaddsub arbiter.
package fpaddsub_arb_pkg;

    localparam int MAX_LOG_BIT = 5;
    localparam int MAX_BIT     = 1 << MAX_LOG_BIT;
    localparam int ID_W        = 3;

    typedef logic [MAX_BIT-1:0] word_t;
    typedef logic [ID_W-1:0]    req_id_t;

    typedef struct packed {
        logic    valid;
        word_t   a;
        word_t   b;
        logic    sub;
        req_id_t id;
    } s1_t;

    typedef struct packed {
        logic    valid;
        word_t   res;
        req_id_t id;
    } s2_t;

    function automatic int n_bit(input int log_bit);
        return 1 << log_bit;
    endfunction

endpackage

// File: rtl/fpaddsub_arb_fpaddsub.sv
// fpaddsub: combinational IEEE-style add/sub, round-to-nearest-even,
// subnormals, Inf and quiet-NaN handling.
module fpaddsub #(
    parameter int  LOG_BIT = 5,
    parameter int  EXP_BIT = 8,
    localparam int N       = 1 << LOG_BIT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    localparam int M    = N - 1 - EXP_BIT;
    localparam int EMAX = (1 << EXP_BIT) - 1;
    localparam logic [EXP_BIT-1:0] EONE = '1;

    typedef logic [M+3:0] ext_t;

    logic               sa, sb, sx, eff_sub, swap, rup;
    logic               nan_a, nan_b, inf_a, inf_b;
    logic [EXP_BIT-1:0] ea, eb;
    logic [M-1:0]       fa, fb;
    logic [M:0]         mx, my;
    logic [2*M+3:0]     yfull;
    ext_t               xal, yal, n;
    logic [M+4:0]       sum;
    logic [M+1:0]       mr;
    int                 ex, ey, d, lz, sh, en;

    always_comb begin
        sa      = a[N-1];
        sb      = b[N-1] ^ sub;
        ea      = a[N-2:M];
        eb      = b[N-2:M];
        fa      = a[M-1:0];
        fb      = b[M-1:0];
        nan_a   = (ea == EONE) && (fa != '0);
        nan_b   = (eb == EONE) && (fb != '0);
        inf_a   = (ea == EONE) && (fa == '0);
        inf_b   = (eb == EONE) && (fb == '0);
        eff_sub = sa ^ sb;
        // x is the larger magnitude so the difference never goes negative
        swap    = {eb, fb} > {ea, fa};
        sx      = swap ? sb : sa;
        mx      = swap ? {|eb, fb} : {|ea, fa};
        my      = swap ? {|ea, fa} : {|eb, fb};
        ex      = int'(swap ? eb : ea);
        ey      = int'(swap ? ea : eb);
        if (ex == 0) ex = 1;
        if (ey == 0) ey = 1;
        d       = ex - ey;
        xal     = {mx, 3'b000};
        yfull   = {my, {(M+3){1'b0}}} >> d;
        if (d >= M + 4)
            yal = ext_t'(|my);
        else
            yal = yfull[2*M+3:M] | ext_t'(|yfull[M-1:0]);
        sum = eff_sub ? ({1'b0, xal} - {1'b0, yal})
                      : ({1'b0, xal} + {1'b0, yal});

        lz = M + 4;
        for (int i = 0; i < M + 4; i++)
            if (sum[i]) lz = M + 3 - i;
        sh = 0;
        if (sum[M+4]) begin
            n  = {sum[M+4:2], sum[1] | sum[0]};
            en = ex + 1;
        end else begin
            // left shift stops at the subnormal exponent
            sh = (lz < ex - 1) ? lz : ex - 1;
            n  = sum[M+3:0] << sh;
            en = ex - sh;
        end

        rup = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[M+3:3]} + {{(M+1){1'b0}}, rup};
        if (mr[M+1]) begin
            en = en + 1;
            mr = mr >> 1;
        end

        y = {sx, (mr[M] ? EXP_BIT'(en) : {EXP_BIT{1'b0}}), mr[M-1:0]};
        if (mr[M] && en >= EMAX) y = {sx, EONE, {M{1'b0}}};
        if (sum == '0) y = {sa & sb, {(N-1){1'b0}}};
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub))
            y = {1'b0, EONE, 1'b1, {(M-1){1'b0}}};
        else if (inf_a)
            y = {sa, EONE, {M{1'b0}}};
        else if (inf_b)
            y = {sb, EONE, {M{1'b0}}};
    end

endmodule

// File: rtl/fpaddsub_arb.sv
// fpaddsub_arb: N requesters share one 2-stage fpaddsub pipeline.
// Define FPADDSUB_ARB_RR_EN for round-robin grant, else fixed priority.
module fpaddsub_arb
    import fpaddsub_arb_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  LOG_BIT = 5,
    parameter int  EXP_BIT = 8,
    localparam int N_BIT   = n_bit(LOG_BIT),
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][N_BIT-1:0] req_a,
    input  logic [N_REQ-1:0][N_BIT-1:0] req_b,
    input  logic [N_REQ-1:0]            req_sub,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_BIT-1:0]            rsp_data,
    output logic [IDW-1:0]              rsp_id,
    output logic                        busy
);

    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic             s2_adv, s1_can, found;
    logic [IDW-1:0]   win, idx;
    logic [N_BIT-1:0] dp_y;

`ifdef FPADDSUB_ARB_RR_EN
    logic [IDW-1:0] rr_q, rr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef FPADDSUB_ARB_RR_EN
            idx = IDW'((int'(rr_q) + k) % N_REQ);
`else
            idx = IDW'(k);
`endif
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        s2_adv    = !s2_q.valid || rsp_ready;
        s1_can    = !s1_q.valid || s2_adv;
        req_ready = '0;
        if (found && s1_can) req_ready[win] = 1'b1;

        s1_d = s1_q;
        if (s1_can) begin
            s1_d.valid = found;
            if (found) begin
                s1_d.a   = word_t'(req_a[win]);
                s1_d.b   = word_t'(req_b[win]);
                s1_d.sub = req_sub[win];
                s1_d.id  = req_id_t'(win);
            end
        end

        // payload only moves with a real operation, so a stalled result stays put
        s2_d = s2_q;
        if (s2_adv) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.res = word_t'(dp_y);
                s2_d.id  = s1_q.id;
            end
        end

`ifdef FPADDSUB_ARB_RR_EN
        rr_d = rr_q;
        if (found && s1_can)
            rr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    fpaddsub #(
        .LOG_BIT (LOG_BIT),
        .EXP_BIT (EXP_BIT)
    ) u_dp (
        .a   (N_BIT'(s1_q.a)),
        .b   (N_BIT'(s1_q.b)),
        .sub (s1_q.sub),
        .y   (dp_y)
    );

    assign rsp_valid = s2_q.valid;
    assign rsp_data  = N_BIT'(s2_q.res);
    assign rsp_id    = IDW'(s2_q.id);
    assign busy      = s1_q.valid | s2_q.valid;

endmodule

// File: tb/tb_fpaddsub_arb.sv
// Scoreboard bench for fpaddsub_arb: accepts push expected results,
// a monitor pops and compares each delivered response.
module tb_fpaddsub_arb;

    localparam int NR = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0][31:0]  req_a;
    logic [NR-1:0][31:0]  req_b;
    logic [NR-1:0]        req_sub;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic [1:0]           rsp_id;
    logic                 busy;

    logic [31:0] a_v [NR];
    logic [31:0] b_v [NR];
    logic [31:0] e_v [NR];
    logic        s_v [NR];
    logic [3:0]  exp_g [5];

    typedef struct {
        logic [31:0] d;
        logic [1:0]  id;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc;
    bit          lat_en = 1'b1;
    bit          held_v = 1'b0;
    logic [31:0] held_d;
    logic [1:0]  held_id;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_a[i]   = a_v[i];
            req_b[i]   = b_v[i];
            req_sub[i] = s_v[i];
        end
    end

    fpaddsub_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i])
                    sb_q.push_back('{d: e_v[i], id: 2'(i),
                                     cyc: cyc, lat: lat_en});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else if (rsp_valid) begin
            if (held_v) begin
                check("hold_data", rsp_data, held_d);
                check("hold_id", 32'(rsp_id), 32'(held_id));
            end
            if (rsp_ready) begin
                held_v = 1'b0;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got %h id %0d want none",
                             rsp_data, rsp_id);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", rsp_data, e.d);
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end else begin
                held_v  = 1'b1;
                held_d  = rsp_data;
                held_id = rsp_id;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(t >= 50), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        a_v[0] = 32'h3F800000; b_v[0] = 32'h40000000;
        s_v[0] = 1'b0;         e_v[0] = 32'h40400000;
        a_v[1] = 32'h3F800000; b_v[1] = 32'h3F800000;
        s_v[1] = 1'b1;         e_v[1] = 32'h00000000;
        a_v[2] = 32'h7FC00000; b_v[2] = 32'h3F800000;
        s_v[2] = 1'b0;         e_v[2] = 32'h7FC00000;
        a_v[3] = 32'h40000000; b_v[3] = 32'h3F000000;
        s_v[3] = 1'b1;         e_v[3] = 32'h3FC00000;
`ifdef FPADDSUB_ARB_RR_EN
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
`else
        for (int i = 0; i < 5; i++) exp_g[i] = 4'b0001;
`endif
        req_valid = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;

        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single op from requester 0, 1.0 + 2.0
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // all requesters valid, arbitration order from a fresh pointer
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t2_grant", 32'(req_ready), 32'(exp_g[c]));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drain();

        // consumer stall with continuous requests
        lat_en    = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        acc       = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acc += $countones(req_valid & req_ready);
            if (c >= 2) check("t3_ready_low", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        check("t3_accepts", 32'(acc), 32'd2);
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();
        lat_en = 1'b1;

        // each requester alone; requester 0 now 1.5 + 2.5 (carry out)
        a_v[0] = 32'h3FC00000;
        b_v[0] = 32'h40200000;
        e_v[0] = 32'h40800000;
        for (int r = 0; r < NR; r++) begin
            req_valid = 4'(1 << r);
            @(negedge clk);
            check("t4_ready", 32'(req_ready), 32'(1 << r));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drain();

        // reset with both stages full
        lat_en    = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        repeat (2) @(posedge clk);
        #1;
        check("t5_full_valid", 32'(rsp_valid), 32'd1);
        check("t5_full_busy", 32'(busy), 32'd1);
        req_valid = '0;
        rst       = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        lat_en    = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        check("t5_first_accept", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
        repeat (5) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
